parking_occupancy_counter: RTL and testbench
============================================

Name: parking_occupancy_counter

Overview:
Downstream consumer of the parking-gate FSM's one-cycle entrada/salida pulses. It keeps the number of cars currently inside and mirrors that number as two BCD digits for the lot display. It also raises full/empty status and sticky overflow/underflow error flags for the supervisor logic. It sits between the gate FSM and the display/indicator drivers.

Parameters:
CAPACITY, 20, maximum number of cars allowed inside; legal range 1..99.
CNT_W, 7, width of the binary occupancy count; must hold CAPACITY.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
entrada  input  1  one-cycle pulse: a car completed an entry
salida  input  1  one-cycle pulse: a car completed an exit
clr  input  1  synchronous clear of count and error flags
count  output  CNT_W  binary number of cars inside
bcd_tens  output  4  tens digit of count, BCD
bcd_units  output  4  units digit of count, BCD
full  output  1  high when count == CAPACITY
empty  output  1  high when count == 0
reject  output  1  one-cycle pulse: an entry or exit was refused at a boundary
err_overflow  output  1  sticky: entry seen while full
err_underflow  output  1  sticky: exit seen while empty

Behaviour:
- Reset: the clock is clk; reset is reset, asynchronous, active-high. While reset is asserted: count=0, bcd_tens=0, bcd_units=0, full=0, empty=1, reject=0, err_overflow=0, err_underflow=0.
- All outputs are registered. An input pulse sampled at rising edge N is reflected in every output after edge N (1-cycle latency).
- Priority per edge: clr > simultaneous event > single event.
- clr=1: count, BCD digits, err_* and reject all go to 0; entrada/salida are ignored that cycle.
- entrada=1 and salida=1 in the same cycle: net zero. Count is unchanged, no error, reject=0, at every count value including 0 and CAPACITY.
- entrada only, count < CAPACITY: count+1.
- entrada only, count == CAPACITY: count held, reject=1 for one cycle, err_overflow set.
- salida only, count > 0: count-1.
- salida only, count == 0: count held, reject=1 for one cycle, err_underflow set.
- The err_* flags stay set until clr or reset. Setting a flag does not block later legal events.
- BCD tracking: the digits are kept by incremental BCD counters, not by division.
  - Increment: units 9 wraps to 0 and tens increments.
  - Decrement: units 0 wraps to 9 and tens decrements.
  - Invariant every cycle: bcd_tens*10 + bcd_units == count.
- full and empty are registered from the next-count value, so they are coherent with count on the same cycle.
- Input pulses longer than one cycle are counted once per cycle high; this block does no edge detection.
- Reset asserted mid-operation returns all outputs to reset values immediately. Counting resumes on the first edge after reset deasserts.

Optional Feature:
Macro OCCUPANCY_STATS_EN.
- Defined: adds outputs total_in[15:0] and total_out[15:0].
  - total_in counts accepted entries; total_out counts accepted exits.
  - In the simultaneous case both counters increment.
  - Both counters saturate at 16'hFFFF.
  - Both are cleared by reset and by clr.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset asserted, then released -> count=0, bcd=0/0, empty=1, full=0, err_*=0, reject=0.
2. 12 entrada pulses, one every 3 cycles -> count=12, bcd_tens=1, bcd_units=2; at 9->10 the digits go 0/9 -> 1/0 on a single edge.
3. CAPACITY=20: fill to 20, then one extra entrada -> count stays 20, full=1, reject pulses for 1 cycle, err_overflow=1; then salida -> count=19, full=0, err_overflow still 1.
4. From count=10, one salida -> bcd goes 1/0 -> 0/9. From count=0, one salida -> count=0, reject pulse, err_underflow=1. Then clr -> err_underflow=0.
5. entrada and salida high together at count=0, at count=20 and at count=7 -> count unchanged, reject=0, no error. With OCCUPANCY_STATS_EN, total_in and total_out each +1.
6. Reset asserted mid-sequence at count=15 with err_overflow=1 -> all outputs at reset values within the same cycle. With OCCUPANCY_STATS_EN, 70000 accepted entries -> total_in=16'hFFFF.

Source files
------------

// File: rtl/parking_occupancy_counter.sv
// Parking-lot occupancy counter: tracks cars inside as binary count and BCD digits, with full/empty status and sticky boundary errors.
// Define OCCUPANCY_STATS_EN to add saturating total_in/total_out event counters.
module parking_occupancy_counter #(
    parameter int unsigned CAPACITY = 20,
    parameter int unsigned CNT_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entrada,
    input  logic             salida,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             err_overflow,
`ifdef OCCUPANCY_STATS_EN
    output logic [15:0]      total_in,
    output logic [15:0]      total_out,
`endif
    output logic             err_underflow
);

    localparam int unsigned     STAT_W = 16;
    localparam logic [CNT_W-1:0] CAP   = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] count_d;
    logic [3:0]       tens_d;
    logic [3:0]       units_d;
    logic             full_d;
    logic             empty_d;
    logic             reject_d;
    logic             err_overflow_d;
    logic             err_underflow_d;
    logic             inc;
    logic             dec;
    logic             acc_in;
    logic             acc_out;

    // Event decode: clr beats simultaneous beats single events
    always_comb begin
        inc             = 1'b0;
        dec             = 1'b0;
        acc_in          = 1'b0;
        acc_out         = 1'b0;
        reject_d        = 1'b0;
        err_overflow_d  = err_overflow;
        err_underflow_d = err_underflow;
        if (clr) begin
            err_overflow_d  = 1'b0;
            err_underflow_d = 1'b0;
        end else if (entrada && salida) begin
            acc_in  = 1'b1;
            acc_out = 1'b1;
        end else if (entrada) begin
            if (count == CAP) begin
                reject_d       = 1'b1;
                err_overflow_d = 1'b1;
            end else begin
                inc    = 1'b1;
                acc_in = 1'b1;
            end
        end else if (salida) begin
            if (count == '0) begin
                reject_d        = 1'b1;
                err_underflow_d = 1'b1;
            end else begin
                dec     = 1'b1;
                acc_out = 1'b1;
            end
        end
    end

    // Next count and incremental BCD digits
    always_comb begin
        count_d = count;
        tens_d  = bcd_tens;
        units_d = bcd_units;
        if (clr) begin
            count_d = '0;
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc) begin
            count_d = count + CNT_W'(1);
            if (bcd_units == 4'd9) begin
                units_d = 4'd0;
                tens_d  = bcd_tens + 4'd1;
            end else begin
                units_d = bcd_units + 4'd1;
            end
        end else if (dec) begin
            count_d = count - CNT_W'(1);
            if (bcd_units == 4'd0) begin
                units_d = 4'd9;
                tens_d  = bcd_tens - 4'd1;
            end else begin
                units_d = bcd_units - 4'd1;
            end
        end
        full_d  = (count_d == CAP);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            bcd_tens      <= 4'd0;
            bcd_units     <= 4'd0;
            full          <= 1'b0;
            empty         <= 1'b1;
            reject        <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            count         <= count_d;
            bcd_tens      <= tens_d;
            bcd_units     <= units_d;
            full          <= full_d;
            empty         <= empty_d;
            reject        <= reject_d;
            err_overflow  <= err_overflow_d;
            err_underflow <= err_underflow_d;
        end
    end

`ifdef OCCUPANCY_STATS_EN
    logic [STAT_W-1:0] total_in_d;
    logic [STAT_W-1:0] total_out_d;

    // Saturating accepted-event totals
    always_comb begin
        total_in_d  = total_in;
        total_out_d = total_out;
        if (clr) begin
            total_in_d  = '0;
            total_out_d = '0;
        end else begin
            if (acc_in && (total_in != {STAT_W{1'b1}}))
                total_in_d = total_in + STAT_W'(1);
            if (acc_out && (total_out != {STAT_W{1'b1}}))
                total_out_d = total_out + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_in  <= '0;
            total_out <= '0;
        end else begin
            total_in  <= total_in_d;
            total_out <= total_out_d;
        end
    end
`else
    logic stats_unused;
    assign stats_unused = acc_in ^ acc_out ^ (STAT_W == 0);
`endif

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed self-checking bench for parking_occupancy_counter (CAPACITY=20).
module tb_parking_occupancy_counter;

    localparam int unsigned CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             entrada;
    logic             salida;
    logic             clr;
    logic [CNT_W-1:0] count;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_units;
    logic             full;
    logic             empty;
    logic             reject;
    logic             err_overflow;
    logic             err_underflow;
`ifdef OCCUPANCY_STATS_EN
    logic [15:0]      total_in;
    logic [15:0]      total_out;
`endif

    int vectors    = 0;
    int miscompares = 0;

    parking_occupancy_counter #(.CAPACITY(20), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .entrada       (entrada),
        .salida        (salida),
        .clr           (clr),
        .count         (count),
        .bcd_tens      (bcd_tens),
        .bcd_units     (bcd_units),
        .full          (full),
        .empty         (empty),
        .reject        (reject),
        .err_overflow  (err_overflow),
`ifdef OCCUPANCY_STATS_EN
        .total_in      (total_in),
        .total_out     (total_out),
`endif
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input int fl, input int em,
                               input int rej, input int eo, input int eu);
        check({tag, ".count"},  int'(count), cnt);
        check({tag, ".tens"},   int'(bcd_tens), cnt / 10);
        check({tag, ".units"},  int'(bcd_units), cnt % 10);
        check({tag, ".full"},   int'(full), fl);
        check({tag, ".empty"},  int'(empty), em);
        check({tag, ".reject"}, int'(reject), rej);
        check({tag, ".err_ov"}, int'(err_overflow), eo);
        check({tag, ".err_un"}, int'(err_underflow), eu);
    endtask

    // Drive one cycle of inputs; outputs are settled at the following negedge
    task automatic step(input logic e, input logic s, input logic c);
        @(negedge clk);
        entrada = e;
        salida  = s;
        clr     = c;
        @(negedge clk);
        entrada = 1'b0;
        salida  = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic steps(input int n, input logic e, input logic s);
        for (int i = 0; i < n; i++) step(e, s, 1'b0);
    endtask

    initial begin
        reset = 1'b1; entrada = 1'b0; salida = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        check_state("rst_held", 0, 0, 1, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_state("rst_rel", 0, 0, 1, 0, 0, 0);

        // 12 spaced entries with the 9 -> 10 BCD carry
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 9)  check_state("ent9", 9, 0, 0, 0, 0, 0);
            if (i == 10) check_state("ent10", 10, 0, 0, 0, 0, 0);
            repeat (2) @(negedge clk);
        end
        check_state("ent12", 12, 0, 0, 0, 0, 0);

        // Fill to capacity, then overflow
        steps(8, 1'b1, 1'b0);
        check_state("fill20", 20, 1, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        check_state("ovf", 20, 1, 0, 1, 1, 0);
        @(negedge clk);
        check_state("ovf_next", 20, 1, 0, 0, 1, 0);
        step(1'b0, 1'b1, 1'b0);
        check_state("exit19", 19, 0, 0, 0, 1, 0);

        // Decrement through 10 -> 9 borrow
        steps(9, 1'b0, 1'b1);
        check_state("down10", 10, 0, 0, 0, 1, 0);
        step(1'b0, 1'b1, 1'b0);
        check_state("down9", 9, 0, 0, 0, 1, 0);

        // clr wins over a concurrent entry
        step(1'b1, 1'b0, 1'b1);
        check_state("clr", 0, 0, 1, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        check_state("unf", 0, 0, 1, 1, 0, 1);
        step(1'b0, 1'b0, 1'b1);
        check_state("clr_unf", 0, 0, 1, 0, 0, 0);

        // Simultaneous events at 0, 7 and 20
        step(1'b1, 1'b1, 1'b0);
        check_state("sim0", 0, 0, 1, 0, 0, 0);
        steps(7, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_state("sim7", 7, 0, 0, 0, 0, 0);
        steps(13, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_state("sim20", 20, 1, 0, 0, 0, 0);

        // Stretched pulse counts every high cycle
        steps(6, 1'b0, 1'b1);
        @(negedge clk);
        salida = 1'b1;
        repeat (3) @(negedge clk);
        salida = 1'b0;
        check_state("long_exit", 11, 0, 0, 0, 0, 0);

        // Async reset mid-operation at 15 with overflow flagged
        steps(9, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        steps(5, 1'b0, 1'b1);
        check_state("pre_rst", 15, 0, 0, 0, 1, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_state("mid_rst", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check_state("resume", 1, 0, 0, 0, 0, 0);

`ifdef OCCUPANCY_STATS_EN
        step(1'b0, 1'b0, 1'b1);
        check("tin_clr", int'(total_in), 0);
        step(1'b1, 1'b1, 1'b0);
        check("tin_sim", int'(total_in), 1);
        check("tout_sim", int'(total_out), 1);
        @(negedge clk);
        entrada = 1'b1;
        salida  = 1'b1;
        repeat (70000) @(negedge clk);
        entrada = 1'b0;
        salida  = 1'b0;
        check("tin_sat", int'(total_in), 65535);
        check("tout_sat", int'(total_out), 65535);
        check("cnt_sat", int'(count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
